// File: rtl/ternary_fetch_queue_dual_if.sv
// Instruction-memory fetch bus for the dual-issue ternary fetch queue.
// One request carries the address of an instruction pair; the response
// returns the instruction at that address (rdata_a) and at address+1
// (rdata_b).
//   imem_req     master -> slave  fetch request for one instruction pair
//   imem_addr    master -> slave  address of the first instruction
//   imem_gnt     slave  -> master request accepted this cycle
//   imem_rvalid  slave  -> master pair data valid
//   imem_rdata_a slave  -> master instruction at imem_addr
//   imem_rdata_b slave  -> master instruction at imem_addr + 1
// Trit encoding: 2'b00 = zero, 2'b01 = +1, 2'b10 = -1.

typedef logic [1:0] trit_t;
localparam trit_t T_ZERO = 2'b00;

interface ternary_fetch_queue_dual_if #(
  parameter int PC_W        = 8,
  parameter int INSTR_TRITS = 9
);
  logic                    imem_req;
  logic [PC_W-1:0]         imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  trit_t [INSTR_TRITS-1:0] imem_rdata_a;
  trit_t [INSTR_TRITS-1:0] imem_rdata_b;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata_a, imem_rdata_b
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata_a, imem_rdata_b
  );
endinterface

// File: rtl/ternary_fetch_queue_dual.sv
// Dual-issue fetch queue for a ternary core. Fetches instruction pairs from
// instruction memory (one request in flight at a time), buffers them in
// program order in a circular buffer and presents the two oldest entries to
// decode as slot A / slot B.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   imem             fetch bus (master side)
//   pc_stall         load-use stall, blocks dequeue
//   id_issue_b       decode also consumes slot B this cycle
//   redirect_valid   flush the queue and restart fetch at redirect_pc
//   redirect_pc      new fetch address (odd values allowed)
//   id_valid_a/b     slot holds a valid instruction
//   id_instr_a/b     slot instruction (all zero trits when invalid)
//   id_pc_a/b        slot address (zero when invalid)

module ternary_fetch_queue_dual #(
  parameter int              DEPTH       = 4,
  parameter int              PC_W        = 8,
  parameter int              INSTR_TRITS = 9,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  ternary_fetch_queue_dual_if.master imem,
  input  logic                    pc_stall,
  input  logic                    id_issue_b,
  input  logic                    redirect_valid,
  input  logic [PC_W-1:0]         redirect_pc,
  output logic                    id_valid_a,
  output logic                    id_valid_b,
  output trit_t [INSTR_TRITS-1:0] id_instr_a,
  output trit_t [INSTR_TRITS-1:0] id_instr_b,
  output logic [PC_W-1:0]         id_pc_a,
  output logic [PC_W-1:0]         id_pc_b
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Entry storage (data, not reset)
  trit_t [INSTR_TRITS-1:0] instr_mem_q [DEPTH];
  logic  [PC_W-1:0]        pc_mem_q    [DEPTH];
  logic  [PC_W-1:0]        req_pc_q;

  // Control state
  cnt_t            count_q, count_d;
  ptr_t            rd_ptr_q, rd_ptr_d;
  ptr_t            wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;

  logic valid_a, valid_b;
  logic fire, rsp_done, enq;
  cnt_t free_slots, deq_n;
  ptr_t rd_ptr_b, wr_ptr_b;

  always_comb begin
    valid_a    = !rst && (count_q != '0);
    valid_b    = !rst && (count_q > cnt_t'(1));
    free_slots = cnt_t'(DEPTH) - count_q;
    rd_ptr_b   = rd_ptr_q + ptr_t'(1);
    wr_ptr_b   = wr_ptr_q + ptr_t'(1);

    // Space for a whole pair is reserved before requesting, so an accepted
    // response can always be enqueued without overflow.
    imem.imem_req  = !rst && !redirect_valid && !outstanding_q &&
                     (free_slots >= cnt_t'(2));
    imem.imem_addr = fetch_pc_q;

    fire     = imem.imem_req && imem.imem_gnt;
    // Any rvalid while outstanding closes the transaction; it only delivers
    // data when the request was not orphaned by a redirect.
    rsp_done = imem.imem_rvalid && outstanding_q;
    enq      = rsp_done && !drop_q && !rst && !redirect_valid;

    deq_n = '0;
    if (!rst && !redirect_valid && !pc_stall) begin
      deq_n = cnt_t'(valid_a) + cnt_t'(valid_b && id_issue_b);
    end
  end

  always_comb begin
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (redirect_valid) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      fetch_pc_d    = redirect_pc;
      // A response still in flight must be swallowed when it arrives.
      outstanding_d = outstanding_q && !imem.imem_rvalid;
      drop_d        = outstanding_q && !imem.imem_rvalid;
    end else begin
      rd_ptr_d = rd_ptr_q + ptr_t'(deq_n);
      count_d  = count_q - deq_n + (enq ? cnt_t'(2) : cnt_t'(0));
      if (enq) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(2);
      end
      if (fire) begin
        outstanding_d = 1'b1;
        fetch_pc_d    = fetch_pc_q + PC_W'(2);
      end else if (rsp_done) begin
        outstanding_d = 1'b0;
        drop_d        = 1'b0;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  // Data registers: the pair lands in two consecutive slots
  always_ff @(posedge clk) begin
    if (fire) begin
      req_pc_q <= fetch_pc_q;
    end
    if (enq) begin
      instr_mem_q[wr_ptr_q] <= imem.imem_rdata_a;
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_b] <= imem.imem_rdata_b;
      pc_mem_q[wr_ptr_b]    <= req_pc_q + PC_W'(1);
    end
  end

  always_comb begin
    id_valid_a = valid_a;
    id_valid_b = valid_b;
    id_instr_a = valid_a ? instr_mem_q[rd_ptr_q] : {INSTR_TRITS{T_ZERO}};
    id_instr_b = valid_b ? instr_mem_q[rd_ptr_b] : {INSTR_TRITS{T_ZERO}};
    id_pc_a    = valid_a ? pc_mem_q[rd_ptr_q] : '0;
    id_pc_b    = valid_b ? pc_mem_q[rd_ptr_b] : '0;
  end

endmodule

// File: tb/tb_ternary_fetch_queue_dual.sv
module tb_ternary_fetch_queue_dual;
  localparam int DEPTH = 4;
  localparam int PC_W  = 8;
  localparam int NT    = 9;
  localparam int IW    = 2 * NT;
  localparam logic [PC_W-1:0] RST_PC = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            pc_stall, id_issue_b, redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            id_valid_a, id_valid_b;
  trit_t [NT-1:0]  id_instr_a, id_instr_b;
  logic [PC_W-1:0] id_pc_a, id_pc_b;

  ternary_fetch_queue_dual_if #(.PC_W(PC_W), .INSTR_TRITS(NT)) imem_if ();

  ternary_fetch_queue_dual #(
    .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_TRITS(NT), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst), .imem(imem_if),
    .pc_stall(pc_stall), .id_issue_b(id_issue_b),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid_a(id_valid_a), .id_valid_b(id_valid_b),
    .id_instr_a(id_instr_a), .id_instr_b(id_instr_b),
    .id_pc_a(id_pc_a), .id_pc_b(id_pc_b)
  );

  int total = 0;
  int bad   = 0;

  // Memory contents: deterministic instruction per address
  function automatic logic [IW-1:0] instr_of(input logic [PC_W-1:0] pc);
    logic [IW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NT; i++) begin
      v = (int'(pc) * 7 + i) % 3;
      r[2*i +: 2] = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : 2'b10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One directed cycle: drive inputs, check outputs mid-cycle, advance.
  task automatic cyc(input string tag, input int r, input int g, input int rv, input int rdpc,
                     input int st, input int ib, input int rd, input int rpc,
                     input int er, input int ea, input int ca,
                     input int eva, input int evb, input int epa, input int epb);
    rst                  = (r != 0);
    imem_if.imem_gnt     = (g != 0);
    imem_if.imem_rvalid  = (rv != 0);
    imem_if.imem_rdata_a = instr_of(PC_W'(rdpc));
    imem_if.imem_rdata_b = instr_of(PC_W'(rdpc + 1));
    pc_stall             = (st != 0);
    id_issue_b           = (ib != 0);
    redirect_valid       = (rd != 0);
    redirect_pc          = PC_W'(rpc);
    @(negedge clk);
    check({tag, " req"}, 64'(imem_if.imem_req), 64'(er != 0));
    if (ca != 0) check({tag, " addr"}, 64'(imem_if.imem_addr), 64'(ea));
    check({tag, " va"}, 64'(id_valid_a), 64'(eva != 0));
    check({tag, " vb"}, 64'(id_valid_b), 64'(evb != 0));
    check({tag, " pca"}, 64'(id_pc_a), (eva != 0) ? 64'(epa) : 64'(0));
    check({tag, " pcb"}, 64'(id_pc_b), (evb != 0) ? 64'(epb) : 64'(0));
    check({tag, " ia"}, 64'(id_instr_a), (eva != 0) ? 64'(instr_of(PC_W'(epa))) : 64'(0));
    check({tag, " ib"}, 64'(id_instr_b), (evb != 0) ? 64'(instr_of(PC_W'(epb))) : 64'(0));
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int r, g, rv, rdpc, st, ib;
    int er, ea, ca, eva, evb, epa, epb;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input int r, input int g, input int rv, input int rdpc, input int st,
                     input int ib, input int er, input int ea, input int ca,
                     input int eva, input int evb, input int epa, input int epb);
    vec_t v;
    v.r = r; v.g = g; v.rv = rv; v.rdpc = rdpc; v.st = st; v.ib = ib;
    v.er = er; v.ea = ea; v.ca = ca; v.eva = eva; v.evb = evb; v.epa = epa; v.epb = epb;
    tbl.push_back(v);
  endtask

  // Reference model state
  typedef struct packed {
    logic [IW-1:0]   instr;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t            mq[$];
  bit              m_out, m_drop;
  logic [PC_W-1:0] m_fpc, m_rpc;

  initial begin
    bit              r_rst, r_red, r_st, r_ib, r_gnt, r_rv, e_req, e_va, e_vb, d_req, pend;
    logic [PC_W-1:0] r_rpc, paddr, d_addr;
    logic [IW-1:0]   da, db;
    int              pwait, n;
    ent_t            e;

    rst = 1'b1; pc_stall = 1'b0; id_issue_b = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_if.imem_gnt = 1'b0; imem_if.imem_rvalid = 1'b0;
    imem_if.imem_rdata_a = '0; imem_if.imem_rdata_b = '0;
    @(posedge clk);
    #1;

    //   r g rv rdpc st ib  er ea ca  va vb pa pb
    // Streaming: grant every cycle, response one cycle after grant
    row(1,0,0,0,   0,1,  0,0,0,     0,0,0,0);
    row(0,1,0,0,   0,1,  1,0,1,     0,0,0,0);
    row(0,1,1,0,   0,1,  0,2,1,     0,0,0,0);
    row(0,1,0,0,   0,1,  1,2,1,     1,1,0,1);
    row(0,1,1,2,   0,1,  0,4,1,     0,0,0,0);
    row(0,1,0,0,   0,1,  1,4,1,     1,1,2,3);
    row(0,1,1,4,   0,1,  0,6,1,     0,0,0,0);
    row(0,1,0,0,   0,1,  1,6,1,     1,1,4,5);
    row(0,1,1,6,   0,1,  0,8,1,     0,0,0,0);
    // Fill under stall, hold 5 cycles full, release
    row(1,0,0,0,   1,1,  0,0,0,     0,0,0,0);
    row(0,1,0,0,   1,1,  1,0,1,     0,0,0,0);
    row(0,1,1,0,   1,1,  0,2,1,     0,0,0,0);
    row(0,1,0,0,   1,1,  1,2,1,     1,1,0,1);
    row(0,1,1,2,   1,1,  0,4,1,     1,1,0,1);
    for (int k = 0; k < 5; k++) row(0,1,0,0, 1,1, 0,4,1, 1,1,0,1);
    row(0,1,0,0,   0,1,  0,4,1,     1,1,0,1);
    row(0,1,0,0,   0,1,  1,4,1,     1,1,2,3);
    row(0,1,1,4,   0,1,  0,6,1,     0,0,0,0);
    // Refill to 4, then single issue from 4 and from 3 entries
    row(0,1,0,0,   1,1,  1,6,1,     1,1,4,5);
    row(0,1,1,6,   1,1,  0,8,1,     1,1,4,5);
    row(0,0,0,0,   0,0,  0,8,1,     1,1,4,5);
    row(0,0,0,0,   0,0,  0,8,1,     1,1,5,6);
    row(0,0,0,0,   1,1,  1,8,1,     1,1,6,7);
    row(0,0,0,0,   1,1,  1,8,1,     1,1,6,7);

    foreach (tbl[k]) begin
      cyc($sformatf("vec%0d", k), tbl[k].r, tbl[k].g, tbl[k].rv, tbl[k].rdpc, tbl[k].st,
          tbl[k].ib, 0, 0, tbl[k].er, tbl[k].ea, tbl[k].ca, tbl[k].eva, tbl[k].evb,
          tbl[k].epa, tbl[k].epb);
    end

    // Redirect while a request is outstanding; stale response discarded
    //      tag     r g rv rdpc st ib rd rpc    er ea   ca va vb pa   pb
    cyc("redir0", 1,0,0,0,    0,1, 0,0,     0,0,   0, 0,0,0,   0);
    cyc("redir1", 0,1,0,0,    0,1, 0,0,     1,0,   1, 0,0,0,   0);
    cyc("redir2", 0,1,0,0,    0,1, 1,8'h15, 0,2,   1, 0,0,0,   0);
    cyc("redir3", 0,1,0,0,    0,1, 0,0,     0,8'h15,1,0,0,0,   0);
    cyc("redir4", 0,1,1,0,    0,1, 0,0,     0,8'h15,1,0,0,0,   0);
    cyc("redir5", 0,1,0,0,    0,1, 0,0,     1,8'h15,1,0,0,0,   0);
    cyc("redir6", 0,0,1,8'h15,0,1, 0,0,     0,8'h17,1,0,0,0,   0);
    cyc("redir7", 0,0,0,0,    1,1, 0,0,     1,8'h17,1,1,1,8'h15,8'h16);
    // Fetch address wrap at the top of the address space
    cyc("wrap0",  0,0,0,0,    0,1, 1,8'hFE, 0,8'h17,1,1,1,8'h15,8'h16);
    cyc("wrap1",  0,1,0,0,    0,1, 0,0,     1,8'hFE,1,0,0,0,   0);
    cyc("wrap2",  0,0,1,8'hFE,0,1, 0,0,     0,8'h00,1,0,0,0,   0);
    cyc("wrap3",  0,0,0,0,    1,1, 0,0,     1,8'h00,1,1,1,8'hFE,8'hFF);
    // Reset with a response in flight; it arrives right after reset
    cyc("rstx0",  0,1,0,0,    1,1, 0,0,     1,8'h00,1,1,1,8'hFE,8'hFF);
    cyc("rstx1",  1,0,0,0,    1,1, 0,0,     0,0,   0, 0,0,0,   0);
    cyc("rstx2",  0,0,1,8'h00,0,1, 0,0,     1,RST_PC,1,0,0,0,  0);
    cyc("rstx3",  0,0,0,0,    0,1, 0,0,     1,RST_PC,1,0,0,0,  0);

    // Randomized run against the queue-based reference model
    pend = 1'b0; pwait = 0; paddr = '0;
    mq.delete(); m_out = 1'b0; m_drop = 1'b0; m_fpc = RST_PC; m_rpc = '0;
    for (int ci = 0; ci < 3000; ci++) begin
      r_rst = (ci == 0) || ($urandom_range(0, 99) == 0);
      r_red = ($urandom_range(0, 19) == 0);
      r_rpc = PC_W'($urandom);
      r_st  = ($urandom_range(0, 3) == 0);
      r_ib  = ($urandom_range(0, 1) == 1);
      r_gnt = ($urandom_range(0, 1) == 1);
      if (pend && pwait == 0) begin
        r_rv = 1'b1;
        da = instr_of(paddr);
        db = instr_of(PC_W'(paddr + 1));
      end else begin
        r_rv = !pend && ($urandom_range(0, 19) == 0);
        da = IW'($urandom);
        db = IW'($urandom);
      end
      rst = r_rst; redirect_valid = r_red; redirect_pc = r_rpc;
      pc_stall = r_st; id_issue_b = r_ib;
      imem_if.imem_gnt = r_gnt; imem_if.imem_rvalid = r_rv;
      imem_if.imem_rdata_a = da; imem_if.imem_rdata_b = db;

      @(negedge clk);
      e_req = !r_rst && !r_red && !m_out && ((DEPTH - mq.size()) >= 2);
      e_va  = !r_rst && (mq.size() >= 1);
      e_vb  = !r_rst && (mq.size() >= 2);
      check("rnd req", 64'(imem_if.imem_req), 64'(e_req));
      if (!r_rst) check("rnd addr", 64'(imem_if.imem_addr), 64'(m_fpc));
      check("rnd va", 64'(id_valid_a), 64'(e_va));
      check("rnd vb", 64'(id_valid_b), 64'(e_vb));
      if (e_va) begin
        check("rnd pca", 64'(id_pc_a), 64'(mq[0].pc));
        check("rnd ia", 64'(id_instr_a), 64'(mq[0].instr));
      end else begin
        check("rnd pca", 64'(id_pc_a), 64'(0));
        check("rnd ia", 64'(id_instr_a), 64'(0));
      end
      if (e_vb) begin
        check("rnd pcb", 64'(id_pc_b), 64'(mq[1].pc));
        check("rnd ib", 64'(id_instr_b), 64'(mq[1].instr));
      end else begin
        check("rnd pcb", 64'(id_pc_b), 64'(0));
        check("rnd ib", 64'(id_instr_b), 64'(0));
      end
      d_req  = imem_if.imem_req;
      d_addr = imem_if.imem_addr;

      @(posedge clk);
      if (r_rst) begin
        mq.delete(); m_fpc = RST_PC; m_out = 1'b0; m_drop = 1'b0;
      end else if (r_red) begin
        mq.delete();
        m_fpc = r_rpc;
        if (m_out) begin
          if (r_rv) begin m_out = 1'b0; m_drop = 1'b0; end
          else m_drop = 1'b1;
        end
      end else begin
        n = 0;
        if (!r_st) n = ((mq.size() >= 1) ? 1 : 0) + ((mq.size() >= 2 && r_ib) ? 1 : 0);
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        if (e_req && r_gnt) begin
          m_out = 1'b1;
          m_rpc = m_fpc;
          m_fpc = PC_W'(m_fpc + 2);
        end else if (m_out && r_rv) begin
          if (!m_drop) begin
            e.instr = da; e.pc = m_rpc;               mq.push_back(e);
            e.instr = db; e.pc = PC_W'(m_rpc + 1);    mq.push_back(e);
          end
          m_out = 1'b0;
          m_drop = 1'b0;
        end
      end
      // Memory responder
      if (r_rst) pend = 1'b0;
      else if (pend && pwait == 0 && r_rv) pend = 1'b0;
      else if (pend) pwait--;
      if (!r_rst && d_req && r_gnt) begin
        pend  = 1'b1;
        paddr = d_addr;
        pwait = $urandom_range(0, 3);
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ternary_fetch_queue_dual.md
TERNARY_FETCH_QUEUE_DUAL -- requirements
Module: ternary_fetch_queue_dual

Interface
REQ-001 SHALL have parameters (name, default, meaning): DEPTH, 4, queue entries (power of two, >=4); PC_W, 8, binary word-address width; INSTR_TRITS, 9, trits per instruction; RESET_PC, 0, fetch address after reset.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  out  1  fetch request for one instruction pair.
REQ-005 SHALL have port imem_addr  out  PC_W  address of the first instruction of the pair.
REQ-006 SHALL have port imem_gnt  in  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid  in  1  pair data valid.
REQ-008 SHALL have ports imem_rdata_a / imem_rdata_b  in  trit_t[INSTR_TRITS-1:0]  instruction at addr / addr+1.
REQ-009 SHALL have port pc_stall  in  1  load-use stall from the dual hazard unit; blocks dequeue.
REQ-010 SHALL have port id_issue_b  in  1  decode accepts slot B alongside slot A this cycle.
REQ-011 SHALL have ports redirect_valid  in  1 and redirect_pc  in  PC_W  branch/jump redirect.
REQ-012 SHALL have ports id_valid_a, id_valid_b  out  1  slot holds a valid instruction.
REQ-013 SHALL have ports id_instr_a, id_instr_b  out  trit_t[INSTR_TRITS-1:0] and id_pc_a, id_pc_b  out  PC_W  instruction and its address.

Function
REQ-014 SHALL hold up to DEPTH {instr, pc} entries in program order in a circular buffer with count 0..DEPTH.
REQ-015 SHALL drive id_valid_a = (count>=1), id_valid_b = (count>=2); slot A = oldest entry, slot B = next-oldest.
REQ-016 SHALL drive id_instr_x to all T_ZERO and id_pc_x to 0 when id_valid_x is 0.
REQ-017 SHALL dequeue per cycle, when !pc_stall and !redirect_valid: 1 if id_valid_a, plus 1 if id_valid_b && id_issue_b; 0 when pc_stall.
REQ-018 SHALL ignore id_issue_b when id_valid_b is 0.
REQ-019 SHALL assert imem_req combinationally when !rst, !redirect_valid, no response outstanding, and (DEPTH - count) >= 2; imem_addr = fetch_pc.
REQ-020 SHALL, on imem_req && imem_gnt, set outstanding, latch req_pc = fetch_pc, and set fetch_pc = fetch_pc + 2 mod 2^PC_W.
REQ-021 SHALL keep imem_addr stable while imem_req is high without imem_gnt; imem_gnt with imem_req low SHALL be ignored.
REQ-022 SHALL allow at most one outstanding request; response latency from grant is arbitrary (>=1 cycle).
REQ-023 SHALL, on imem_rvalid with outstanding and not dropping, enqueue rdata_a at req_pc then rdata_b at req_pc+1 (mod 2^PC_W) and clear outstanding; enqueue and dequeue in the same cycle SHALL net correctly (count += 2 - deq).
REQ-024 SHALL ignore imem_rvalid when nothing is outstanding.
REQ-025 SHALL, on redirect_valid, have priority over stall, dequeue and enqueue: next cycle count=0, fetch_pc=redirect_pc; an outstanding response not arriving this cycle SHALL be marked drop, and its later rvalid discarded, clearing outstanding and drop.
REQ-026 SHALL accept odd redirect_pc values unchanged (pairs need not be aligned).
REQ-027 SHALL never overflow: space for a pair is reserved at request time; count SHALL never exceed DEPTH.

Reset
REQ-028 SHALL, while rst is high, force imem_req=0, id_valid_a=id_valid_b=0, and next state count=0, fetch_pc=RESET_PC, outstanding=0, drop=0, pointers=0.
REQ-029 SHALL discard any response arriving after a reset asserted mid-transaction (outstanding cleared, no enqueue).

Verification
REQ-030 Reset release, gnt=1 every cycle, rvalid 1 cycle after gnt, pc_stall=0, id_issue_b=1 -> imem_addr sequence 0,2,4,...; slots show pc 0/1, 2/3, ... with no gaps after fill.
REQ-031 Queue full (count=4), pc_stall=1 for 5 cycles -> imem_req=0, outputs stable at pc 0/1; release -> dequeue 2 per cycle.
REQ-032 count=3, pc_stall=0, id_issue_b=0 -> one entry dequeued, slot A pc advances by 1, count=2.
REQ-033 Redirect to 0x15 while request outstanding; old rvalid arrives 2 cycles later -> discarded; next request addr 0x15; slots show pc 0x15/0x16.
REQ-034 fetch_pc=0xFE (PC_W=8), grant -> fetch_pc=0x00; enqueued pcs 0xFE, 0xFF.
REQ-035 rst asserted with response outstanding, rvalid during first post-reset cycle -> no enqueue, id_valid_a=0, imem_addr=RESET_PC.
